// File: rtl/rf_wb_queue_pkg.sv
// Shared definitions for the register-file writeback queue.
// Default geometry (32-bit data, 5-bit register address, 4 entries) and the queued entry record.
// x0 is the hardwired zero register; writes to it never enter the queue.
package rf_wb_queue_pkg;

  localparam int RF_XLEN  = 32;
  localparam int RF_AW    = 5;
  localparam int RF_DEPTH = 4;

  localparam logic [RF_AW-1:0] RF_X0 = '0;

  typedef struct packed {
    logic               valid;
    logic [RF_AW-1:0]   rd;
    logic [RF_XLEN-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// In-order writeback storage: circular buffer with per-entry valid, wrap pointers and occupancy count.
// Latency: an entry pushed at edge N is at the head in cycle N+1 when the buffer was empty.
// Backpressure: push is ignored while full and pop while empty; the caller gates ready on full.
module rf_wb_fifo
  import rf_wb_queue_pkg::*;
#(
  parameter int DEPTH = RF_DEPTH,
  parameter int XLEN  = RF_XLEN,
  parameter int AW    = RF_AW,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [AW-1:0]              push_rd,
  input  logic [XLEN-1:0]            push_data,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic [AW-1:0]              head_rd,
  output logic [XLEN-1:0]            head_data,
  output logic [PW-1:0]              head_ptr,
  output logic [DEPTH-1:0]           ent_vld,
  output logic [DEPTH-1:0][AW-1:0]   ent_rd,
  output logic [DEPTH-1:0][XLEN-1:0] ent_data
);

  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_ptr  = rd_ptr;
  assign head_rd   = ent_rd[rd_ptr];
  assign head_data = ent_data[rd_ptr];

  // Storage, pointers and count; reset drops every queued entry at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ent_vld  <= '0;
      ent_rd   <= '0;
      ent_data <= '0;
    end else begin
      // Clear before set: a push never targets the head slot unless the buffer was empty.
      if (do_pop) begin
        ent_vld[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + 1'b1;
      end
      if (do_push) begin
        ent_vld[wr_ptr]  <= 1'b1;
        ent_rd[wr_ptr]   <= push_rd;
        ent_data[wr_ptr] <= push_data;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rf_wb_queue.sv
// Writeback front end: arbitrates load/ALU results into an in-order queue drained onto WE3/A3/WD3.
// Latency: 1 cycle from acceptance to the write port when empty, at most DEPTH cycles; one write per cycle.
// Backpressure: both readies drop while full; load wins, ALU stalls whenever ld_valid is high. Bypass outputs need RF_WB_BYPASS_EN.
module rf_wb_queue
  import rf_wb_queue_pkg::*;
#(
  parameter int DEPTH = RF_DEPTH,
  parameter int XLEN  = RF_XLEN,
  parameter int AW    = RF_AW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [AW-1:0]   ld_rd,
  input  logic [XLEN-1:0] ld_data,
  output logic            WE3,
  output logic [AW-1:0]   A3,
  output logic [XLEN-1:0] WD3,
  input  logic [AW-1:0]   q_rs1,
  input  logic [AW-1:0]   q_rs2,
  output logic            byp1_hit,
  output logic            byp2_hit,
  output logic [XLEN-1:0] byp1_data,
  output logic [XLEN-1:0] byp2_data,
  output logic            busy
);

  localparam int PW = $clog2(DEPTH);

  logic                       full;
  logic                       empty;
  logic                       ld_fire;
  logic                       alu_fire;
  logic                       push;
  logic [AW-1:0]              push_rd;
  logic [XLEN-1:0]            push_data;
  logic [AW-1:0]              head_rd;
  logic [XLEN-1:0]            head_data;
  logic [PW-1:0]              head_ptr;
  logic [DEPTH-1:0]           ent_vld;
  logic [DEPTH-1:0][AW-1:0]   ent_rd;
  logic [DEPTH-1:0][XLEN-1:0] ent_data;

  // Ready comes from the pre-edge occupancy only, so a full queue never passes a request through.
  assign ld_ready  = !full;
  assign alu_ready = !full && !ld_valid;
  assign ld_fire   = ld_valid && ld_ready;
  assign alu_fire  = alu_valid && alu_ready;

  // Select the accepted request; x0 writes finish their handshake but are dropped here.
  always_comb begin
    push_rd   = ld_fire ? ld_rd : alu_rd;
    push_data = ld_fire ? ld_data : alu_data;
    push      = (ld_fire || alu_fire) && (push_rd != '0);
  end

  rf_wb_fifo #(
    .DEPTH (DEPTH),
    .XLEN  (XLEN),
    .AW    (AW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_rd   (push_rd),
    .push_data (push_data),
    .pop       (!empty),
    .full      (full),
    .empty     (empty),
    .head_rd   (head_rd),
    .head_data (head_data),
    .head_ptr  (head_ptr),
    .ent_vld   (ent_vld),
    .ent_rd    (ent_rd),
    .ent_data  (ent_data)
  );

  // Head drives the write port combinationally so reset removes WE3 without a clock.
  always_comb begin
    WE3  = !empty;
    A3   = empty ? '0 : head_rd;
    WD3  = empty ? '0 : head_data;
    busy = !empty;
  end

`ifdef RF_WB_BYPASS_EN
  logic [PW-1:0] idx1;
  logic [PW-1:0] idx2;

  // Walk oldest to youngest so the last match (youngest) overrides earlier ones.
  always_comb begin
    byp1_hit  = 1'b0;
    byp1_data = '0;
    idx1      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx1 = head_ptr + PW'(k);
      if (ent_vld[idx1] && (q_rs1 != '0) && (ent_rd[idx1] == q_rs1)) begin
        byp1_hit  = 1'b1;
        byp1_data = ent_data[idx1];
      end
    end
  end

  // Same youngest-wins search for the second read port.
  always_comb begin
    byp2_hit  = 1'b0;
    byp2_data = '0;
    idx2      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx2 = head_ptr + PW'(k);
      if (ent_vld[idx2] && (q_rs2 != '0) && (ent_rd[idx2] == q_rs2)) begin
        byp2_hit  = 1'b1;
        byp2_data = ent_data[idx2];
      end
    end
  end
`else
  // No bypass: decode has to stall on busy for dependent registers.
  logic unused_byp;
  assign unused_byp = ^{q_rs1, q_rs2, head_ptr, ent_vld, ent_rd, ent_data};
  assign byp1_hit   = 1'b0;
  assign byp2_hit   = 1'b0;
  assign byp1_data  = '0;
  assign byp2_data  = '0;
`endif

endmodule
